// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiter.
package uart_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone
    } tx_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_wr_en;
    logic                      tx_busy;
    logic                      grant_valid;
    logic [IDX_W-1:0]          grant_idx;
    logic                      err_timeout;

    // Environment side: requesters plus the transmitter's busy flag.
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_wr_en, grant_valid, grant_idx, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_wr_en, grant_valid, grant_idx, err_timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams;
// a grant is held for a whole message so messages never interleave.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

    tx_state_e         state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  grant_idx_q;
    logic              grant_valid_q;
    logic              tx_wr_en_q;
    logic              err_timeout_q;
    logic              last_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic              own_valid;
    logic              own_last;
    logic [BYTE_W-1:0] own_data;
    logic [NUM_REQ-1:0] req_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign own_valid = bus.req_valid[grant_idx_q];
    assign own_last  = bus.req_last[grant_idx_q];
    assign next_ptr  = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                own_data = bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // The byte is taken on the same edge that leaves LOAD, so ready marks that cycle.
    always_comb begin
        req_ready = '0;
        if (state_q == StLoad && own_valid) begin
            req_ready[grant_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            tx_wr_en_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            last_q        <= 1'b0;
            tx_data_q     <= '0;
            cnt_q         <= '0;
        end else begin
            tx_wr_en_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found && !bus.tx_busy) begin
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= pick_idx;
                        state_q       <= StLoad;
                    end
                end
                StLoad: begin
                    if (own_valid) begin
                        tx_data_q  <= own_data;
                        tx_wr_en_q <= 1'b1;
                        last_q     <= own_last;
                        cnt_q      <= '0;
                        state_q    <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (bus.tx_busy) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // Byte is dropped; the message owner loses its turn.
                        err_timeout_q <= 1'b1;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= next_ptr;
                        state_q       <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            grant_valid_q <= 1'b0;
                            ptr_q         <= next_ptr;
                            state_q       <= StIdle;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_wr_en    = tx_wr_en_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy-for-N-cycles transmitter model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned BUSY_TIMEOUT = 16;
    localparam int          BUSY_CYC     = 10;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } ev_t;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]         rq [NUM_REQ][$];
    logic [NUM_REQ-1:0] took;
    logic               model_dead = 1'b0;
    int                 busy_cnt   = 0;
    ev_t                wr_log [$];
    int                 ready_cnt [NUM_REQ];
    int                 multi_ready   = 0;
    int                 wr_while_busy = 0;
    int                 err_pulses    = 0;

    // Transmitter model: busy for BUSY_CYC cycles per accepted byte, ignores rst_n.
    assign bus.tx_busy = (busy_cnt != 0);
    always @(posedge clk_50m) begin
        if (bus.tx_wr_en && busy_cnt == 0 && !model_dead) busy_cnt <= BUSY_CYC;
        else if (busy_cnt != 0)                           busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk_50m) begin
        if (bus.tx_wr_en) wr_log.push_back({bus.grant_idx, bus.tx_data});
        if (bus.tx_wr_en && bus.tx_busy) wr_while_busy <= wr_while_busy + 1;
        if ($countones(bus.req_ready) > 1) multi_ready <= multi_ready + 1;
        if (bus.err_timeout) err_pulses <= err_pulses + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
        end
    end

    // Requester models: present queue heads, pop on an observed ready pulse.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
        forever begin
            @(negedge clk_50m);
            took = bus.req_ready;
            @(posedge clk_50m);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (took[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[i*8 +: 8] = rq[i][0][7:0];
                    bus.req_last[i]        = rq[i][0][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_50m);
            #1;
        end
    endtask

    function automatic bit drained();
        drained = !bus.grant_valid && !bus.tx_busy;
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) drained = 1'b0;
    endfunction

    task automatic test_reset;
        cyc(1);
        n_tests++;
        if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_grant: got valid=%b idx=%0d, want 0/0", bus.grant_valid, bus.grant_idx);
        end
        n_tests++;
        if (bus.tx_wr_en !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx: got wr_en=%b data=%h, want 0/00", bus.tx_wr_en, bus.tx_data);
        end
        n_tests++;
        if (bus.req_ready !== 4'b0000 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misc: got ready=%b err=%b, want 0000/0", bus.req_ready, bus.err_timeout);
        end
        rst_n = 1'b1;
        cyc(3);
        n_tests++;
        if (bus.grant_valid !== 1'b0 || bus.tx_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got valid=%b wr_en=%b, want 0/0", bus.grant_valid, bus.tx_wr_en);
        end
    endtask

    task automatic test_single;
        int  base = wr_log.size();
        int  r2   = ready_cnt[2];
        ev_t exp [2];
        ev_t got;
        exp[0] = {2'd2, 8'h41};
        exp[1] = {2'd2, 8'h42};
        rq[2].push_back({1'b0, 8'h41});
        rq[2].push_back({1'b1, 8'h42});
        for (int k = 0; k < 200 && wr_log.size() < base + 2; k++) cyc(1);
        for (int k = 0; k < 20 && !bus.tx_busy; k++) cyc(1);
        for (int k = 0; k < 20 && bus.tx_busy; k++) cyc(1);
        n_tests++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL single_hold_at_busy_fall: got valid=%b idx=%0d, want 1/2",
                     bus.grant_valid, bus.grant_idx);
        end
        cyc(1);
        n_tests++;
        if (bus.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got valid=%b, want 0", bus.grant_valid);
        end
        n_tests++;
        if (wr_log.size() != base + 2) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes, want 2", wr_log.size() - base);
        end
        for (int k = 0; k < 2; k++) begin
            got = (wr_log.size() > base + k) ? wr_log[base + k] : '1;
            n_tests++;
            if (got !== exp[k]) begin
                n_fail++;
                $display("FAIL single_byte%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         k, got.idx, got.data, exp[k].idx, exp[k].data);
            end
        end
        n_tests++;
        if (ready_cnt[2] - r2 != 2) begin
            n_fail++;
            $display("FAIL single_ready: got %0d pulses on req_ready[2], want 2", ready_cnt[2] - r2);
        end
    endtask

    task automatic test_contention;
        int  base;
        ev_t exp [5];
        ev_t got;
        exp[0] = {2'd0, 8'hA0};
        exp[1] = {2'd3, 8'hA3};
        exp[2] = {2'd0, 8'hB0};
        exp[3] = {2'd1, 8'hB1};
        exp[4] = {2'd3, 8'hB3};
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        base = wr_log.size();
        rq[0].push_back({1'b1, 8'hA0});
        rq[3].push_back({1'b1, 8'hA3});
        cyc(2);
        for (int k = 0; k < 300 && !drained(); k++) cyc(1);
        rq[0].push_back({1'b1, 8'hB0});
        rq[1].push_back({1'b1, 8'hB1});
        rq[3].push_back({1'b1, 8'hB3});
        cyc(2);
        for (int k = 0; k < 400 && !drained(); k++) cyc(1);
        n_tests++;
        if (wr_log.size() != base + 5) begin
            n_fail++;
            $display("FAIL contention_count: got %0d writes, want 5", wr_log.size() - base);
        end
        for (int k = 0; k < 5; k++) begin
            got = (wr_log.size() > base + k) ? wr_log[base + k] : '1;
            n_tests++;
            if (got !== exp[k]) begin
                n_fail++;
                $display("FAIL contention_order%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         k, got.idx, got.data, exp[k].idx, exp[k].data);
            end
        end
    endtask

    task automatic test_lock;
        int  base = wr_log.size();
        ev_t exp [4];
        ev_t got;
        exp[0] = {2'd1, 8'h10};
        exp[1] = {2'd1, 8'h11};
        exp[2] = {2'd1, 8'h12};
        exp[3] = {2'd0, 8'h20};
        rq[1].push_back({1'b0, 8'h10});
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        for (int k = 0; k < 20 && !(bus.grant_valid && bus.grant_idx == 2'd1); k++) cyc(1);
        n_tests++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL lock_grant: got valid=%b idx=%0d, want 1/1", bus.grant_valid, bus.grant_idx);
        end
        rq[0].push_back({1'b1, 8'h20});
        cyc(2);
        for (int k = 0; k < 400 && !drained(); k++) cyc(1);
        for (int k = 0; k < 4; k++) begin
            got = (wr_log.size() > base + k) ? wr_log[base + k] : '1;
            n_tests++;
            if (got !== exp[k]) begin
                n_fail++;
                $display("FAIL lock_order%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         k, got.idx, got.data, exp[k].idx, exp[k].data);
            end
        end
    endtask

    task automatic test_gap;
        int  base = wr_log.size();
        int  lost = 0;
        int  gap_base;
        ev_t exp [3];
        ev_t got;
        exp[0] = {2'd1, 8'h51};
        exp[1] = {2'd1, 8'h52};
        exp[2] = {2'd0, 8'h60};
        rq[1].push_back({1'b0, 8'h51});
        for (int k = 0; k < 50 && wr_log.size() < base + 1; k++) cyc(1);
        rq[0].push_back({1'b1, 8'h60});
        gap_base = wr_log.size();
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (!(bus.grant_valid === 1'b1 && bus.grant_idx === 2'd1)) lost++;
        end
        n_tests++;
        if (lost != 0) begin
            n_fail++;
            $display("FAIL gap_grant_held: got %0d cycles without grant to 1, want 0", lost);
        end
        n_tests++;
        if (wr_log.size() != gap_base) begin
            n_fail++;
            $display("FAIL gap_no_write: got %0d writes during gap, want 0", wr_log.size() - gap_base);
        end
        rq[1].push_back({1'b1, 8'h52});
        cyc(2);
        for (int k = 0; k < 400 && !drained(); k++) cyc(1);
        for (int k = 0; k < 3; k++) begin
            got = (wr_log.size() > base + k) ? wr_log[base + k] : '1;
            n_tests++;
            if (got !== exp[k]) begin
                n_fail++;
                $display("FAIL gap_order%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         k, got.idx, got.data, exp[k].idx, exp[k].data);
            end
        end
    endtask

    task automatic test_timeout;
        int  base = wr_log.size();
        int  e0   = err_pulses;
        int  n    = 0;
        ev_t exp [2];
        ev_t got;
        exp[0] = {2'd2, 8'h77};
        exp[1] = {2'd3, 8'h88};
        model_dead = 1'b1;
        rq[2].push_back({1'b1, 8'h77});
        rq[3].push_back({1'b1, 8'h88});
        for (int k = 0; k < 50 && wr_log.size() < base + 1; k++) cyc(1);
        for (int k = 0; k < 40 && bus.err_timeout !== 1'b1; k++) begin
            cyc(1);
            n++;
        end
        n_tests++;
        if (n != BUSY_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_latency: got err %0d cycles after wr_en, want %0d", n, BUSY_TIMEOUT);
        end
        n_tests++;
        if (bus.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release: got valid=%b, want 0", bus.grant_valid);
        end
        for (int k = 0; k < 50 && wr_log.size() < base + 2; k++) cyc(1);
        n_tests++;
        if (bus.grant_idx !== 2'd3 || bus.tx_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_next: got idx=%0d wr_en=%b, want 3/1", bus.grant_idx, bus.tx_wr_en);
        end
        for (int k = 0; k < 100 && !drained(); k++) cyc(1);
        cyc(2);
        n_tests++;
        if (err_pulses - e0 != 2) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d err pulses, want 2", err_pulses - e0);
        end
        for (int k = 0; k < 2; k++) begin
            got = (wr_log.size() > base + k) ? wr_log[base + k] : '1;
            n_tests++;
            if (got !== exp[k]) begin
                n_fail++;
                $display("FAIL timeout_byte%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         k, got.idx, got.data, exp[k].idx, exp[k].data);
            end
        end
        model_dead = 1'b0;
    endtask

    task automatic test_reset_mid;
        int  base;
        int  early = 0;
        ev_t exp [2];
        ev_t got;
        exp[0] = {2'd1, 8'hD1};
        exp[1] = {2'd3, 8'hD3};
        // Serve requester 1 first so the pointer sits at 2 before reset.
        rq[1].push_back({1'b1, 8'hC1});
        cyc(2);
        for (int k = 0; k < 200 && !drained(); k++) cyc(1);
        base = wr_log.size();
        rq[2].push_back({1'b1, 8'hC2});
        for (int k = 0; k < 50 && wr_log.size() < base + 1; k++) cyc(1);
        for (int k = 0; k < 20 && !bus.tx_busy; k++) cyc(1);
        cyc(2);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 2'd0 || bus.tx_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got valid=%b idx=%0d wr_en=%b, want 0/0/0",
                     bus.grant_valid, bus.grant_idx, bus.tx_wr_en);
        end
        n_tests++;
        if (bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0000 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_misc: got data=%h ready=%b err=%b, want 00/0000/0",
                     bus.tx_data, bus.req_ready, bus.err_timeout);
        end
        cyc(2);
        rst_n = 1'b1;
        base = wr_log.size();
        rq[1].push_back({1'b1, 8'hD1});
        rq[3].push_back({1'b1, 8'hD3});
        n_tests++;
        if (bus.tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_frame_alive: got tx_busy=%b after reset, want 1", bus.tx_busy);
        end
        for (int k = 0; k < 20 && bus.tx_busy; k++) begin
            if (bus.grant_valid) early++;
            cyc(1);
        end
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL rst_mid_wait_busy: got %0d granted cycles while busy, want 0", early);
        end
        cyc(2);
        for (int k = 0; k < 300 && !drained(); k++) cyc(1);
        for (int k = 0; k < 2; k++) begin
            got = (wr_log.size() > base + k) ? wr_log[base + k] : '1;
            n_tests++;
            if (got !== exp[k]) begin
                n_fail++;
                $display("FAIL rst_mid_order%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         k, got.idx, got.data, exp[k].idx, exp[k].data);
            end
        end
    endtask

    task automatic test_invariants;
        n_tests++;
        if (wr_while_busy != 0) begin
            n_fail++;
            $display("FAIL wr_en_while_busy: got %0d cycles, want 0", wr_while_busy);
        end
        n_tests++;
        if (multi_ready != 0) begin
            n_fail++;
            $display("FAIL ready_onehot: got %0d multi-bit cycles, want 0", multi_ready);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_lock;
        test_gap;
        test_timeout;
        test_reset_mid;
        test_invariants;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
